memif_bram_responder: RTL and testbench
=======================================

// Module: memif_bram_responder
// PURPOSE
// - Block-RAM responder for the sdram-style rd/wr burst request interface: the memory end of the link the testbench drives.
// - Drop-in replacement for the sdram controller in sim and on small FPGAs: no PLL, no init delay, deterministic latency.
// - Lets traffic generators and checkers be verified against a known-good memory before running on real SDRAM.
// PARAMETERS
// - BANKBITS  2   bank bits of request address (address width AW = BANKBITS+ROWBITS+COLBITS)
// - ROWBITS   13  row bits of request address
// - COLBITS   10  column bits of request address
// - MEMBITS   12  RAM depth = 2**MEMBITS 16-bit words; addresses use low MEMBITS bits only
// - RD_LAT    2   cycles from rd_ack to first rd_rdy, range 1..4
// PORTS
// - clk      in   1    sole clock
// - reset_n  in   1    async active-low reset
// - rd_addr  in   AW   read start word address, stable while rd_req high
// - rd_len   in   4    read burst length minus one (1..16 words)
// - rd_req   in   1    read request, held until rd_ack
// - rd_ack   out  1    1-cycle pulse: read accepted; initiator may drop/change request next cycle
// - rd_data  out  16   read data, valid when rd_rdy
// - rd_rdy   out  1    one pulse per returned word, in address order
// - wr_addr  in   AW   write start word address, stable while wr_req high
// - wr_len   in   4    write burst length minus one
// - wr_data  in   16   write word; sampled in each cycle wr_ack is high
// - wr_req   in   1    write request, held until last wr_ack
// - wr_ack   out  1    one pulse per word consumed; initiator presents next word the following cycle
// BEHAVIOUR
// - Reset: rd_ack=0, rd_rdy=0, rd_data=0, wr_ack=0, FSM=IDLE, arbiter priority=READ. RAM contents not reset.
// - FSM: IDLE, RD_ACK, RD_BURST, WR_BURST. One transaction at a time; no read/write overlap.
// - IDLE: sample requests; both high same cycle -> grant side with priority, then priority flips to other side.
//   Only one high -> grant it (priority unchanged). Latch addr[MEMBITS-1:0] and len into counters.
// - Read: IDLE->RD_ACK (rd_ack=1 for exactly that cycle) -> RD_BURST. rd_ack cycle = T; word k on rd_rdy at T+RD_LAT+k.
//   rd_rdy contiguous, len+1 pulses; FSM returns to IDLE after last RAM read issued; pipeline drains in parallel.
//   New request accepted only once pipeline empty: next rd_ack never earlier than cycle after last rd_rdy.
// - Write: IDLE->WR_BURST; wr_ack high len+1 consecutive cycles starting the cycle after grant; RAM written with wr_data
//   each wr_ack cycle at current address. IDLE the cycle after last wr_ack. A write-then-read of same address returns new data.
// - Address: increments by 1 per word, wraps modulo 2**MEMBITS (0xFFF -> 0x000 at default); upper addr bits ignored.
// - rd_req/wr_req dropped mid-burst by initiator: ignored, burst completes as latched.
// - reset_n asserted mid-burst: outputs forced 0 immediately; in-flight read words discarded; partial write words already
//   written remain. Counters 4-bit for length, MEMBITS-bit for address; no overflow flags.
// CONFIGURATION
// - MEMIF_BRAM_RESPONDER_STALL_EN defined: 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advanced every cycle;
//   when lfsr[1:0]==2'b00 the burst engine stalls that cycle: no rd_rdy/wr_ack, address/count hold.
//   Stall also delays rd_ack/write grant by one cycle from IDLE. Order and data unchanged; only timing stretches.
// - Undefined: no stalls, latencies exactly as above. LFSR logic absent.
// STRUCTURE
// - Package memif_pkg: memif_state_t enum {IDLE,RD_ACK,RD_BURST,WR_BURST}, MEMIF_LEN_W=4, MEMIF_DATA_W=16, LFSR seed.
// - Sub-module ram_sp: single-port synchronous RAM, 2**MEMBITS x 16, 1-cycle read, write-first; RD_LAT-1 extra
//   output register stages plus valid shift register live in the responder.
// TESTING
// - Reset then write addr 0x010 len 3 data 1111,2222,3333,4444 -> 4 consecutive wr_ack; read back len 3 -> rd_rdy at T+2..T+5 same data.
// - rd_req and wr_req high same cycle after reset -> read granted first; next simultaneous pair -> write granted first.
// - Write len 15 at addr 0xFFA with data=index -> read 0xFFA len 15 returns 0..15; read 0x000 len 0 returns 6 (wrap).
// - RD_LAT=4 build: single read -> exactly 4 cycles rd_ack to rd_rdy; back-to-back reads -> no rd_ack before prior last rd_rdy.
// - reset_n low during 8th word of 16-word read -> rd_rdy 0 same cycle, no further words; after release, IDLE accepts new request.
// - With MEMIF_BRAM_RESPONDER_STALL_EN: 1000 random bursts vs scoreboard -> zero mismatches, at least one stall observed.

Source files
------------

// File: rtl/memif_pkg.sv
// Shared types and constants for the block-RAM burst responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memif_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ACK   = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } memif_state_t;

  localparam int MEMIF_LEN_W  = 4;
  localparam int MEMIF_DATA_W = 16;

  localparam logic [15:0] MEMIF_LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [15:0] memif_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/memif_bram_responder_ram_sp.sv
// Single-port synchronous RAM, write-first, contents never reset.
// Latency: 1 cycle from enabled read to dout; dout holds while en is low.
// Backpressure: none; the caller gates en.
module ram_sp #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_q;

  // Storage and output register; a write also returns the new word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
        dout_q    <= din;
      end else begin
        dout_q <= mem[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/memif_bram_responder.sv
// Block-RAM memory end of the rd/wr burst link; optional random stalls via MEMIF_BRAM_RESPONDER_STALL_EN.
// Latency: rd_ack cycle T, read word k on rd_rdy at T+RD_LAT+k; wr_ack starts the cycle after write grant.
// Backpressure: requests wait in IDLE until the read pipeline drains; stalls freeze engine and pipeline.
module memif_bram_responder
  import memif_pkg::*;
#(
  parameter int BANKBITS = 2,
  parameter int ROWBITS  = 13,
  parameter int COLBITS  = 10,
  parameter int MEMBITS  = 12,
  parameter int RD_LAT   = 2,
  localparam int AW      = BANKBITS + ROWBITS + COLBITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [AW-1:0]           rd_addr,
  input  logic [MEMIF_LEN_W-1:0]  rd_len,
  input  logic                    rd_req,
  output logic                    rd_ack,
  output logic [MEMIF_DATA_W-1:0] rd_data,
  output logic                    rd_rdy,
  input  logic [AW-1:0]           wr_addr,
  input  logic [MEMIF_LEN_W-1:0]  wr_len,
  input  logic [MEMIF_DATA_W-1:0] wr_data,
  input  logic                    wr_req,
  output logic                    wr_ack
);

  localparam logic [MEMBITS-1:0]     ADDR_ONE = 1;
  localparam logic [MEMIF_LEN_W-1:0] LEN_ONE  = 1;

  memif_state_t             state_q, state_d;
  logic                     prio_wr_q, prio_wr_d;   // 0: read wins a tie, 1: write wins
  logic [MEMBITS-1:0]       addr_q, addr_d;
  logic [MEMIF_LEN_W-1:0]   cnt_q, cnt_d;           // words remaining minus one
  logic [RD_LAT-1:0]        vld_q, vld_d;           // read-valid shift register
  logic                     stall;
  logic                     issue;
  logic                     pipe_busy;
  logic                     grant_rd, grant_wr;
  logic [MEMIF_DATA_W-1:0]  ram_dout;
  logic [MEMIF_DATA_W-1:0]  stage [RD_LAT];

  // Only the low MEMBITS of each address select a RAM word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{rd_addr[AW-1:MEMBITS], wr_addr[AW-1:MEMBITS]};

`ifdef MEMIF_BRAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running pseudo-random stall source.
  always_comb begin
    lfsr_d = memif_lfsr_next(lfsr_q);
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= MEMIF_LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Outputs decode directly from flops so reset clears them at once.
  assign rd_ack  = (state_q == RD_ACK);
  assign wr_ack  = (state_q == WR_BURST) && !stall;
  assign rd_rdy  = vld_q[RD_LAT-1] && !stall;
  assign rd_data = rd_rdy ? stage[RD_LAT-1] : '0;

  // Pipeline counts as empty when only the last word is leaving this cycle.
  always_comb begin
    pipe_busy = vld_q[RD_LAT-1] && stall;
    for (int i = 0; i < RD_LAT - 1; i++) pipe_busy = pipe_busy | vld_q[i];
  end

  // Arbitration, burst sequencing and address/count stepping.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stall && !pipe_busy) begin
          grant_rd = rd_req && (!wr_req || !prio_wr_q);
          grant_wr = wr_req && (!rd_req || prio_wr_q);
          if (rd_req && wr_req) prio_wr_d = !prio_wr_q;
          if (grant_rd) begin
            state_d = RD_ACK;
            addr_d  = rd_addr[MEMBITS-1:0];
            cnt_d   = rd_len;
          end else if (grant_wr) begin
            state_d = WR_BURST;
            addr_d  = wr_addr[MEMBITS-1:0];
            cnt_d   = wr_len;
          end
        end
      end
      RD_ACK, RD_BURST: begin
        // Word 0 is issued in the ack cycle so RD_LAT counts from rd_ack.
        if (!stall) begin
          issue = 1'b1;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d = RD_BURST;
            cnt_d   = cnt_q - LEN_ONE;
            addr_d  = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (!stall) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q - LEN_ONE;
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid shift register advances only on non-stalled cycles.
  always_comb begin
    vld_d = vld_q;
    if (!stall) begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_d[i] = vld_q[i-1];
      vld_d[0] = issue;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
    end
  end

  ram_sp #(.AW(MEMBITS), .DW(MEMIF_DATA_W)) u_ram (
    .clk  (clk),
    .en   (issue || wr_ack),
    .we   (wr_ack),
    .addr (addr_q),
    .din  (wr_data),
    .dout (ram_dout)
  );

  assign stage[0] = ram_dout;

  for (genvar g = 1; g < RD_LAT; g++) begin : g_stage
    logic [MEMIF_DATA_W-1:0] dat_q;
    // Extra read-data register stage, frozen during stalls.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    dat_q <= '0;
      else if (!stall) dat_q <= stage[g-1];
    end
    assign stage[g] = dat_q;
  end

endmodule

// File: tb/tb_memif_bram_responder.sv
module tb_memif_bram_responder;

  localparam int AW    = 25;
  localparam int LAT   = 2;
  localparam int BOUND = 100;
`ifdef MEMIF_BRAM_RESPONDER_STALL_EN
  localparam int NRAND = 1000;
`else
  localparam int NRAND = 200;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    rd_len, wr_len;
  logic          rd_req, wr_req, rd_ack, rd_rdy, wr_ack;
  logic [15:0]   rd_data, wr_data;

  logic [AW-1:0] rd_addr4, wr_addr4;
  logic [3:0]    rd_len4, wr_len4;
  logic          rd_req4, wr_req4, rd_ack4, rd_rdy4, wr_ack4;
  logic [15:0]   rd_data4, wr_data4;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_gaps = 0;
  logic [15:0] model [4096];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memif_bram_responder dut (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack)
  );

  memif_bram_responder #(.RD_LAT(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .rd_addr(rd_addr4), .rd_len(rd_len4), .rd_req(rd_req4), .rd_ack(rd_ack4),
    .rd_data(rd_data4), .rd_rdy(rd_rdy4),
    .wr_addr(wr_addr4), .wr_len(wr_len4), .wr_data(wr_data4), .wr_req(wr_req4), .wr_ack(wr_ack4)
  );

  typedef struct packed {
    logic              is_wr;
    logic              drop;
    logic [AW-1:0]     addr;
    logic [3:0]        len;
    logic [15:0][15:0] d;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string nm, input logic [AW-1:0] a, input logic [3:0] l,
                          input logic [15:0][15:0] d, input bit drop);
    int n;
    wr_addr = a; wr_len = l; wr_data = d[0]; wr_req = 1'b1;
    n = 0;
    while (!wr_ack && n < BOUND) begin step(); n++; end
    chk({nm, " first ack"}, 32'(wr_ack), 1);
    for (int k = 0; k <= int'(l); k++) begin
`ifdef MEMIF_BRAM_RESPONDER_STALL_EN
      n = 0;
      while (!wr_ack && n < BOUND) begin step(); n++; stall_gaps++; end
`endif
      chk($sformatf("%s ack %0d", nm, k), 32'(wr_ack), 1);
      if (drop) wr_req = 1'b0;
      step();
      if (k < int'(l)) wr_data = d[k+1];
      else             wr_data = 16'h0;
    end
    chk({nm, " ack ends"}, 32'(wr_ack), 0);
    wr_req = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [3:0] l,
                         input logic [15:0][15:0] e);
    int n, t, got;
    rd_addr = a; rd_len = l; rd_req = 1'b1;
    n = 0;
    while (!rd_ack && n < BOUND) begin step(); n++; end
    chk({nm, " ack seen"}, 32'(rd_ack), 1);
    t = cyc;
    rd_req = 1'b0;
    got = 0;
    n = 0;
    while (got <= int'(l) && n < BOUND) begin
      step();
      n++;
      if (n == 1) chk({nm, " ack one cycle"}, 32'(rd_ack), 0);
      if (rd_rdy) begin
`ifndef MEMIF_BRAM_RESPONDER_STALL_EN
        chk($sformatf("%s w%0d latency", nm, got), 32'(cyc - t), 32'(LAT + got));
`endif
        chk($sformatf("%s w%0d data", nm, got), 32'(rd_data), 32'(e[got]));
        got++;
      end
    end
    chk({nm, " word count"}, 32'(got), 32'(l) + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t              vt [10];
    logic [15:0][15:0] seq, four, abcd, one6, pair, beef, rnd;
    int n, t, t2, lst, early, cnt, off;
    logic [3:0] l;
    logic [AW-1:0] a;

    for (int i = 0; i < 16; i++) seq[i] = 16'(i);
    four = '0; four[0] = 16'h1111; four[1] = 16'h2222; four[2] = 16'h3333; four[3] = 16'h4444;
    abcd = '0; abcd[0] = 16'hA0A0; abcd[1] = 16'hB0B0; abcd[2] = 16'hC0C0; abcd[3] = 16'hD0D0;
    one6 = '0; one6[0] = 16'h0006;
    pair = '0; pair[0] = 16'h1111; pair[1] = 16'h2222;
    beef = '0; beef[0] = 16'hBEEF;
    vt[0] = '{1'b1, 1'b0, 25'h0000010, 4'd3,  four};
    vt[1] = '{1'b0, 1'b0, 25'h0000010, 4'd3,  four};
    vt[2] = '{1'b1, 1'b1, 25'h0000020, 4'd3,  abcd};
    vt[3] = '{1'b0, 1'b0, 25'h0000020, 4'd3,  abcd};
    vt[4] = '{1'b1, 1'b0, 25'h0000FFA, 4'd15, seq};
    vt[5] = '{1'b0, 1'b0, 25'h0000FFA, 4'd15, seq};
    vt[6] = '{1'b0, 1'b0, 25'h0000000, 4'd0,  one6};
    vt[7] = '{1'b0, 1'b0, 25'h1ABC010, 4'd1,  pair};
    vt[8] = '{1'b1, 1'b0, 25'h00007FF, 4'd0,  beef};
    vt[9] = '{1'b0, 1'b0, 25'h00007FF, 4'd0,  beef};

    reset_n = 1'b0;
    rd_addr = '0; rd_len = '0; rd_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_req = 1'b0;
    rd_addr4 = '0; rd_len4 = '0; rd_req4 = 1'b0; wr_addr4 = '0; wr_len4 = '0; wr_data4 = '0; wr_req4 = 1'b0;
    step(); step(); step();
    chk("reset rd_ack", 32'(rd_ack), 0);
    chk("reset rd_rdy", 32'(rd_rdy), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    chk("reset wr_ack", 32'(wr_ack), 0);
    reset_n = 1'b1;
    step();

    // Arbitration: first tie goes to read, next tie to write.
    rd_addr = 25'h300; rd_len = 4'd0; wr_addr = 25'h301; wr_len = 4'd0; wr_data = 16'h0A0A;
    rd_req = 1'b1; wr_req = 1'b1;
    n = 0;
    while (!rd_ack && !wr_ack && n < BOUND) begin step(); n++; end
    chk("arb1 read first", 32'({rd_ack, wr_ack}), 32'b10);
    rd_req = 1'b0;
    n = 0;
    while (!wr_ack && n < BOUND) begin step(); n++; end
    chk("arb1 held write follows", 32'(wr_ack), 1);
    wr_req = 1'b0;
    repeat (6) step();
    rd_req = 1'b1; wr_req = 1'b1;
    n = 0;
    while (!rd_ack && !wr_ack && n < BOUND) begin step(); n++; end
    chk("arb2 write first", 32'({rd_ack, wr_ack}), 32'b01);
    wr_req = 1'b0;
    n = 0;
    while (!rd_ack && n < BOUND) begin step(); n++; end
    chk("arb2 held read follows", 32'(rd_ack), 1);
    rd_req = 1'b0;
    repeat (6) step();

    // Directed burst table.
    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) do_write($sformatf("vec%0d wr", i), vt[i].addr, vt[i].len, vt[i].d, vt[i].drop);
      else             do_read($sformatf("vec%0d rd", i), vt[i].addr, vt[i].len, vt[i].d);
    end

    // Reset during the 8th word of a 16-word read.
    rd_addr = 25'hFFA; rd_len = 4'd15; rd_req = 1'b1;
    n = 0;
    while (!rd_ack && n < BOUND) begin step(); n++; end
    chk("rst ack seen", 32'(rd_ack), 1);
    rd_req = 1'b0;
    repeat (LAT + 7) step();
`ifndef MEMIF_BRAM_RESPONDER_STALL_EN
    chk("rst word7 rdy", 32'(rd_rdy), 1);
    chk("rst word7 data", 32'(rd_data), 7);
`endif
    reset_n = 1'b0;
    #1;
    chk("rst rdy drops", 32'(rd_rdy), 0);
    chk("rst data zero", 32'(rd_data), 0);
    chk("rst rd_ack zero", 32'(rd_ack), 0);
    cnt = 0;
    repeat (3) begin step(); cnt += int'(rd_rdy); end
    reset_n = 1'b1;
    repeat (20) begin step(); cnt += int'(rd_rdy) + int'(rd_ack); end
    chk("rst no further words", 32'(cnt), 0);
    do_read("post-reset rd", 25'h010, 4'd0, four);

    // RD_LAT=4 instance: exact latency and no rd_ack before previous last rd_rdy.
    wr_addr4 = 25'h005; wr_len4 = 4'd0; wr_data4 = 16'h5A5A; wr_req4 = 1'b1;
    n = 0;
    while (!wr_ack4 && n < BOUND) begin step(); n++; end
    chk("lat4 write ack", 32'(wr_ack4), 1);
    wr_req4 = 1'b0;
    step();
    rd_addr4 = 25'h005; rd_len4 = 4'd0; rd_req4 = 1'b1;
    n = 0;
    while (!rd_ack4 && n < BOUND) begin step(); n++; end
    chk("lat4 ack seen", 32'(rd_ack4), 1);
    t = cyc;
    early = 0;
    n = 0;
    do begin step(); n++; early += int'(rd_ack4); end while (!rd_rdy4 && n < BOUND);
`ifndef MEMIF_BRAM_RESPONDER_STALL_EN
    chk("lat4 latency", 32'(cyc - t), 4);
`endif
    chk("lat4 data", 32'(rd_data4), 16'h5A5A);
    chk("lat4 no ack while draining", 32'(early), 0);
    lst = cyc;
    n = 0;
    while (!rd_ack4 && n < BOUND) begin step(); n++; end
    chk("lat4 b2b ack seen", 32'(rd_ack4), 1);
    chk("lat4 b2b ack after last rdy", 32'(cyc > lst), 1);
    t2 = cyc;
    rd_req4 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!rd_rdy4 && n < BOUND);
`ifndef MEMIF_BRAM_RESPONDER_STALL_EN
    chk("lat4 b2b latency", 32'(cyc - t2), 4);
`endif
    chk("lat4 b2b data", 32'(rd_data4), 16'h5A5A);

    // Random bursts in a 64-word window against a reference memory.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 16; k++) begin
        rnd[k] = 16'($urandom);
        model[12'h100 + 16 * b + k] = rnd[k];
      end
      do_write("fill", 25'(12'h100 + 16 * b), 4'd15, rnd, 1'b0);
    end
    for (int i = 0; i < NRAND; i++) begin
      off = $urandom_range(0, 48);
      l = 4'($urandom_range(0, 15));
      a = {13'($urandom), 12'(12'h100 + off)};
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) rnd[k] = 16'($urandom);
        for (int k = 0; k <= int'(l); k++) model[12'h100 + off + k] = rnd[k];
        do_write($sformatf("rnd%0d wr", i), a, l, rnd, 1'b0);
      end else begin
        rnd = '0;
        for (int k = 0; k <= int'(l); k++) rnd[k] = model[12'h100 + off + k];
        do_read($sformatf("rnd%0d rd", i), a, l, rnd);
      end
    end
`ifdef MEMIF_BRAM_RESPONDER_STALL_EN
    chk("stall observed", 32'(stall_gaps > 0), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
